mpu_imul_seq: RTL and testbench

Sequential, parametrised matrix-by-scalar multiplier for the MPU datapath. It multiplies every signed element of a SIZE×SIZE matrix by a signed scalar, processing LANES elements per clock. Results either wrap or saturate, selected per operation, and a sticky overflow flag reports any out-of-range product. It is the clocked successor to the combinational integer-multiply operation and exchanges operands with the MPU controller through a start/busy/done handshake.

---
 rtl/mpu_imul_seq.sv | 119 +++++++++++
 tb/tb_mpu_imul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mpu_imul_seq.sv
// rtl/mpu_imul_seq.sv - sequential matrix-by-scalar multiplier, LANES elements per cycle
module mpu_imul_seq #(
  parameter int SIZE  = 5,
  parameter int WIDTH = 8,
  parameter int LANES = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        saturate,
  input  logic [WIDTH*SIZE*SIZE-1:0]  matrix_a,
  input  logic [WIDTH-1:0]            factor,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [WIDTH*SIZE*SIZE-1:0]  result
);

  localparam int N  = SIZE * SIZE;
  localparam int P  = (N + LANES - 1) / LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // In-range bounds of a WIDTH-bit signed value, sign-extended to product width
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]                 state_q;
  logic [CW-1:0]              chunk_q;
  logic [WIDTH*N-1:0]         a_q;
  logic [WIDTH-1:0]           f_q;
  logic                       sat_q;

  logic [WIDTH*N-1:0]         res_next;
  logic                       lane_ovf;
  int                         idx;
  logic [WIDTH-1:0]           elem;
  logic signed [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]           lane_val;

  // Inactive lanes of a partial final chunk are skipped entirely
  always_comb begin
    res_next = result;
    lane_ovf = 1'b0;
    idx      = 0;
    elem     = '0;
    prod     = '0;
    lane_val = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(chunk_q) * LANES + l;
      if (idx < N) begin
        elem = a_q[WIDTH*idx +: WIDTH];
        prod = $signed({{WIDTH{elem[WIDTH-1]}}, elem}) *
               $signed({{WIDTH{f_q[WIDTH-1]}}, f_q});
        if (prod > PMAX) begin
          lane_ovf = 1'b1;
          lane_val = sat_q ? SMAX : prod[WIDTH-1:0];
        end else if (prod < PMIN) begin
          lane_ovf = 1'b1;
          lane_val = sat_q ? SMIN : prod[WIDTH-1:0];
        end else begin
          lane_val = prod[WIDTH-1:0];
        end
        res_next[WIDTH*idx +: WIDTH] = lane_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chunk_q  <= '0;
      a_q      <= '0;
      f_q      <= '0;
      sat_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            chunk_q  <= '0;
            a_q      <= matrix_a;
            f_q      <= factor;
            sat_q    <= saturate;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          result   <= res_next;
          overflow <= overflow | lane_ovf;
          if (chunk_q == LAST) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            chunk_q <= chunk_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_imul_seq.sv
// tb/tb_mpu_imul_seq.sv - directed self-checking bench for mpu_imul_seq
module tb_mpu_imul_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start4 = 1'b0;
  logic         saturate = 1'b0;
  logic [199:0] matrix_a = '0;
  logic [7:0]   factor = '0;
  logic         busy, done, overflow;
  logic [199:0] result;
  logic         busy4, done4, overflow4;
  logic [199:0] result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpu_imul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .saturate(saturate),
    .matrix_a(matrix_a), .factor(factor),
    .busy(busy), .done(done), .overflow(overflow), .result(result)
  );

  mpu_imul_seq #(.SIZE(5), .WIDTH(8), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .saturate(saturate),
    .matrix_a(matrix_a), .factor(factor),
    .busy(busy4), .done(done4), .overflow(overflow4), .result(result4)
  );

  task automatic load_seq();
    for (int k = 0; k < 25; k++) matrix_a[8*k +: 8] = 8'(k + 1);
  endtask

  function automatic logic [199:0] scaled_seq(input int m);
    logic [199:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = 8'(m * (k + 1));
    return v;
  endfunction

  // Pulse start for one cycle and observe until busy drops (bounded)
  task automatic do_op(input bit use4, input logic sat, input logic [7:0] fac,
                       output int dcyc, output int bcnt, output int dcnt);
    logic b, d;
    saturate = sat;
    factor   = fac;
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    dcyc = -1; bcnt = 0; dcnt = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      b = use4 ? busy4 : busy;
      d = use4 ? done4 : done;
      if (b) bcnt++;
      if (d) begin dcnt++; if (dcyc < 0) dcyc = c; end
      if (!b) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (result !== 200'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (busy4 !== 1'b0 || result4 !== 200'd0) begin errors++; $display("FAIL reset_dut4 busy %0b result %h want 0/0", busy4, result4); end
  endtask

  task automatic test_basic();
    int dc, bc, dn;
    load_seq();
    do_op(1'b0, 1'b0, 8'd2, dc, bc, dn);
    checks++; if (dc !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", dc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", dn); end
    checks++; if (bc !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d want 6", bc); end
    checks++; if (result !== scaled_seq(2)) begin errors++; $display("FAIL basic_result got %h want %h", result, scaled_seq(2)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_wrap_sat();
    int dc, bc, dn;
    load_seq();
    matrix_a[7:0] = 8'd100;
    do_op(1'b0, 1'b0, 8'd2, dc, bc, dn);
    checks++; if (result[7:0] !== 8'hC8) begin errors++; $display("FAIL wrap_pos got %0d want -56", $signed(result[7:0])); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_pos_ovf got %0b want 1", overflow); end
    checks++; if (result[15:8] !== 8'd4) begin errors++; $display("FAIL wrap_pos_elem1 got %0d want 4", result[15:8]); end
    do_op(1'b0, 1'b1, 8'd2, dc, bc, dn);
    checks++; if (result[7:0] !== 8'h7F) begin errors++; $display("FAIL sat_pos got %0d want 127", $signed(result[7:0])); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf got %0b want 1", overflow); end
    matrix_a[7:0] = 8'h9C;
    do_op(1'b0, 1'b1, 8'd2, dc, bc, dn);
    checks++; if (result[7:0] !== 8'h80) begin errors++; $display("FAIL sat_neg got %0d want -128", $signed(result[7:0])); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf got %0b want 1", overflow); end
  endtask

  task automatic test_neg_min();
    int dc, bc, dn;
    load_seq();
    matrix_a[7:0] = 8'h80;
    do_op(1'b0, 1'b0, 8'hFF, dc, bc, dn);
    checks++; if (result[7:0] !== 8'h80) begin errors++; $display("FAIL negmin_wrap got %0d want -128", $signed(result[7:0])); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL negmin_wrap_ovf got %0b want 1", overflow); end
    checks++; if (result[15:8] !== 8'hFE) begin errors++; $display("FAIL negmin_elem1 got %0d want -2", $signed(result[15:8])); end
    do_op(1'b0, 1'b1, 8'hFF, dc, bc, dn);
    checks++; if (result[7:0] !== 8'h7F) begin errors++; $display("FAIL negmin_sat got %0d want 127", $signed(result[7:0])); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL negmin_sat_ovf got %0b want 1", overflow); end
    load_seq();
    do_op(1'b0, 1'b0, 8'd1, dc, bc, dn);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    checks++; if (result !== scaled_seq(1)) begin errors++; $display("FAIL ident_result got %h want %h", result, scaled_seq(1)); end
  endtask

  task automatic test_lanes4();
    int dc, bc, dn;
    load_seq();
    do_op(1'b1, 1'b0, 8'd3, dc, bc, dn);
    checks++; if (dc !== 7) begin errors++; $display("FAIL l4_latency got %0d want 7", dc); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL l4_busy_cycles got %0d want 8", bc); end
    checks++; if (result4[199:192] !== 8'd75) begin errors++; $display("FAIL l4_last got %0d want 75", result4[199:192]); end
    checks++; if (overflow4 !== 1'b0) begin errors++; $display("FAIL l4_ovf got %0b want 0", overflow4); end
    checks++; if (result4 !== scaled_seq(3)) begin errors++; $display("FAIL l4_result got %h want %h", result4, scaled_seq(3)); end
  endtask

  task automatic test_ignore_start();
    int dc = -1;
    logic b6 = 1'b1;
    load_seq();
    saturate = 1'b0;
    factor = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 6) b6 = busy;
      if (done && dc < 0) begin dc = c; start = 1'b1; end
      if (c == 2) begin start = 1'b1; factor = 8'd5; end
      if (c >= 6 && !busy) break;
    end
    start = 1'b0;
    checks++; if (dc !== 5) begin errors++; $display("FAIL ign_latency got %0d want 5", dc); end
    checks++; if (result !== scaled_seq(2)) begin errors++; $display("FAIL ign_result got %h want %h", result, scaled_seq(2)); end
    checks++; if (b6 !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy %0b want 0", b6); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_idle busy %0b done %0b want 0/0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int dc, bc, dn;
    int seen = 0;
    load_seq();
    saturate = 1'b0;
    factor = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags busy %0b done %0b ovf %0b want 0/0/0", busy, done, overflow); end
    checks++; if (result !== 200'd0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
    do_op(1'b0, 1'b0, 8'd2, dc, bc, dn);
    checks++; if (dc !== 5) begin errors++; $display("FAIL midrst_rerun_latency got %0d want 5", dc); end
    checks++; if (result !== scaled_seq(2)) begin errors++; $display("FAIL midrst_rerun_result got %h want %h", result, scaled_seq(2)); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_wrap_sat();
    test_neg_min();
    test_lanes4();
    test_ignore_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
